// File: rtl/div16_pkg.sv
// Shared types and constants for the iterative 16-bit divider.
// Optional feature macro: DIV16_SIGNED_EN (two's-complement operands, extra FIX state).
package div16_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div16_state_e;

  localparam int unsigned DIV16_W     = 16;
  localparam int unsigned DIV16_ITERS = 16;
  localparam int unsigned DIV16_CNT_W = 5;

  localparam logic [DIV16_W-1:0] DIV16_DZ_Q = 16'hFFFF;

endpackage

// File: rtl/cla16.sv
// CLA16: 16-bit two-level carry-lookahead adder (4 groups of 4 bits).
module cla16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [3:0]  w_gc;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Group generate/propagate, block-level carries, then in-group carries.
  always_comb begin
    w_gg   = '0;
    w_gp   = '0;
    w_gc   = '0;
    w_c    = '0;
    o_cout = 1'b0;
    for (int j = 0; j < 4; j++) begin
      w_gg[j] = w_g[4*j+3]
              | (w_p[4*j+3] & w_g[4*j+2])
              | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
              | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
      w_gp[j] = &w_p[4*j +: 4];
    end
    w_gc[0] = i_cin;
    w_gc[1] = w_gg[0] | (w_gp[0] & i_cin);
    w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
    w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
            | (w_gp[2] & w_gp[1] & w_gp[0] & i_cin);
    o_cout  = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
            | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]) | ((&w_gp) & i_cin);
    for (int j = 0; j < 4; j++) begin
      w_c[4*j]   = w_gc[j];
      w_c[4*j+1] = w_g[4*j] | (w_p[4*j] & w_gc[j]);
      w_c[4*j+2] = w_g[4*j+1] | (w_p[4*j+1] & w_g[4*j])
                 | (w_p[4*j+1] & w_p[4*j] & w_gc[j]);
      w_c[4*j+3] = w_g[4*j+2] | (w_p[4*j+2] & w_g[4*j+1])
                 | (w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                 | (w_p[4*j+2] & w_p[4*j+1] & w_p[4*j] & w_gc[j]);
    end
  end

  assign o_sum = w_p ^ w_c;

endmodule

// File: rtl/sub16.sv
// sub16: trial subtractor for the restoring divider, built on CLA16 as X + ~Y + 1.
module sub16
  import div16_pkg::*;
(
  input  logic [DIV16_W:0]   i_rem_shifted,
  input  logic [DIV16_W-1:0] i_divisor,
  output logic [DIV16_W-1:0] o_diff,
  output logic               o_ge
);

  logic w_co;

  cla16 u_cla16 (
    .i_a    (i_rem_shifted[DIV16_W-1:0]),
    .i_b    (~i_divisor),
    .i_cin  (1'b1),
    .o_sum  (o_diff),
    .o_cout (w_co)
  );

  // Divisor has a zero 17th bit, so a set top bit of the shifted remainder always fits.
  assign o_ge = i_rem_shifted[DIV16_W] | w_co;

endmodule

// File: rtl/div16_seq.sv
// div16_seq: iterative restoring divider, one quotient bit per clock.
// Optional feature macro: DIV16_SIGNED_EN (signed operands, one extra FIX cycle).
module div16_seq
  import div16_pkg::*;
#(
  parameter int unsigned WIDTH = DIV16_W  // only 16 is supported
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  div16_state_e r_state, w_state_next;

  logic [DIV16_W-1:0]     r_quo, w_quo_next;
  logic [DIV16_W-1:0]     r_rem, w_rem_next;
  logic [DIV16_W-1:0]     r_div, w_div_next;
  logic [DIV16_CNT_W-1:0] r_cnt, w_cnt_next;
  logic [DIV16_W-1:0]     r_q, w_q_next;
  logic [DIV16_W-1:0]     r_r, w_r_next;
  logic                   r_dz, w_dz_next;

  logic [DIV16_W:0]   w_rem_shift;
  logic [DIV16_W-1:0] w_diff;
  logic               w_ge;
  logic [DIV16_W-1:0] w_quo_iter;
  logic [DIV16_W-1:0] w_rem_iter;
  logic [DIV16_W-1:0] w_x_op;
  logic [DIV16_W-1:0] w_y_op;

`ifdef DIV16_SIGNED_EN
  logic r_neg_q, w_neg_q_next;
  logic r_neg_r, w_neg_r_next;

  assign w_x_op = X[DIV16_W-1] ? (~X + 16'd1) : X;
  assign w_y_op = Y[DIV16_W-1] ? (~Y + 16'd1) : Y;
`else
  assign w_x_op = X;
  assign w_y_op = Y;
`endif

  // Shifted {rem, quo} MSB feeds the trial subtraction.
  assign w_rem_shift = {r_rem, r_quo[DIV16_W-1]};

  sub16 u_sub16 (
    .i_rem_shifted (w_rem_shift),
    .i_divisor     (r_div),
    .o_diff        (w_diff),
    .o_ge          (w_ge)
  );

  assign w_quo_iter = {r_quo[DIV16_W-2:0], w_ge};
  assign w_rem_iter = w_ge ? w_diff : w_rem_shift[DIV16_W-1:0];

  // Next-state and datapath updates.
  always_comb begin
    w_state_next = r_state;
    w_quo_next   = r_quo;
    w_rem_next   = r_rem;
    w_div_next   = r_div;
    w_cnt_next   = r_cnt;
    w_q_next     = r_q;
    w_r_next     = r_r;
    w_dz_next    = r_dz;
`ifdef DIV16_SIGNED_EN
    w_neg_q_next = r_neg_q;
    w_neg_r_next = r_neg_r;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          if (Y == '0) begin
            w_q_next     = DIV16_DZ_Q;
            w_r_next     = X;
            w_dz_next    = 1'b1;
            w_state_next = DONE;
          end else begin
            w_quo_next   = w_x_op;
            w_div_next   = w_y_op;
            w_rem_next   = '0;
            w_cnt_next   = '0;
`ifdef DIV16_SIGNED_EN
            w_neg_q_next = X[DIV16_W-1] ^ Y[DIV16_W-1];
            w_neg_r_next = X[DIV16_W-1];
`endif
            w_state_next = RUN;
          end
        end
      end
      RUN: begin
        w_quo_next = w_quo_iter;
        w_rem_next = w_rem_iter;
        w_cnt_next = r_cnt + DIV16_CNT_W'(1);
        if (r_cnt == DIV16_CNT_W'(DIV16_ITERS - 1)) begin
`ifdef DIV16_SIGNED_EN
          w_state_next = FIX;
`else
          // Load results on entry to DONE so they are valid while done is high.
          w_q_next     = w_quo_iter;
          w_r_next     = w_rem_iter;
          w_dz_next    = 1'b0;
          w_state_next = DONE;
`endif
        end
      end
`ifdef DIV16_SIGNED_EN
      FIX: begin
        w_q_next     = r_neg_q ? (~r_quo + 16'd1) : r_quo;
        w_r_next     = r_neg_r ? (~r_rem + 16'd1) : r_rem;
        w_dz_next    = 1'b0;
        w_state_next = DONE;
      end
`endif
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_quo   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
`ifdef DIV16_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_quo   <= w_quo_next;
      r_rem   <= w_rem_next;
      r_div   <= w_div_next;
      r_cnt   <= w_cnt_next;
      r_q     <= w_q_next;
      r_r     <= w_r_next;
      r_dz    <= w_dz_next;
`ifdef DIV16_SIGNED_EN
      r_neg_q <= w_neg_q_next;
      r_neg_r <= w_neg_r_next;
`endif
    end
  end

  assign busy = (r_state == RUN) || (r_state == FIX);
  assign done = (r_state == DONE);
  assign Q    = r_q;
  assign R    = r_r;
  assign dz   = r_dz;

endmodule

// File: tb/tb_div16_seq.sv
// Self-checking bench for div16_seq against a plain-arithmetic divide model.
// Honours DIV16_SIGNED_EN when the build defines it.
module tb_div16_seq;

`ifdef DIV16_SIGNED_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] q;
  logic [15:0] r;
  logic        busy;
  logic        done;
  logic        dz;

  int n_tests;
  int n_fail;

  div16_seq #(
    .WIDTH (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .X     (x),
    .Y     (y),
    .Q     (q),
    .R     (r),
    .busy  (busy),
    .done  (done),
    .dz    (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: floor division (or truncating signed division), DZ convention for Y=0.
  function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] eq, output logic [15:0] er,
                                  output logic ez);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (b == 16'd0) begin
      eq = 16'hFFFF;
      er = a;
      ez = 1'b1;
    end else begin
`ifdef DIV16_SIGNED_EN
      eq = 16'(sa / sb);
      er = 16'(sa % sb);
`else
      eq = a / b;
      er = a % b;
`endif
      ez = 1'b0;
    end
  endfunction

  // Issue one operation; k_done is the number of post-edge samples after the start edge
  // before done is seen (-1 on timeout). Returns to IDLE before leaving.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       output int k_done, output int n_busy,
                       output logic [15:0] oq, output logic [15:0] orr, output logic oz);
    x = a;
    y = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    k_done = -1;
    n_busy = 0;
    oq = '0;
    orr = '0;
    oz = 1'b0;
    for (int k = 0; k <= 60; k++) begin
      if (done) begin
        k_done = k;
        oq = q;
        orr = r;
        oz = dz;
        break;
      end
      if (busy) n_busy++;
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    x = '0;
    y = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if (q !== 16'd0) begin n_fail++; $display("FAIL reset_q got=%h exp=0000", q); end
    n_tests++;
    if (r !== 16'd0) begin n_fail++; $display("FAIL reset_r got=%h exp=0000", r); end
    n_tests++;
    if ({busy, done, dz} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got busy/done/dz=%b exp=000", {busy, done, dz});
    end
  endtask

  task automatic test_directed();
    logic [15:0] va [4];
    logic [15:0] vb [4];
    int kd, nb;
    logic [15:0] gq, gr, eq, er;
    logic gz, ez;
    va = '{16'd100, 16'hFFFF, 16'd5, 16'd9};
    vb = '{16'd7,   16'd1,    16'd9, 16'd9};
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], kd, nb, gq, gr, gz);
      ref_div(va[i], vb[i], eq, er, ez);
      n_tests++;
      if (gq !== eq || gr !== er || gz !== ez) begin
        n_fail++;
        $display("FAIL directed_%0d/%0d got q=%h r=%h dz=%b exp q=%h r=%h dz=%b",
                 va[i], vb[i], gq, gr, gz, eq, er, ez);
      end
      n_tests++;
      if (kd !== LAT - 1) begin
        n_fail++;
        $display("FAIL latency_%0d/%0d got=%0d exp=%0d", va[i], vb[i], kd + 1, LAT);
      end
      n_tests++;
      if (nb !== LAT - 1) begin
        n_fail++;
        $display("FAIL busy_cycles_%0d/%0d got=%0d exp=%0d", va[i], vb[i], nb, LAT - 1);
      end
      n_tests++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL done_one_cycle got=%b exp=0", done);
      end
    end
  endtask

  task automatic test_div_zero();
    int kd, nb;
    logic [15:0] gq, gr;
    logic gz;
    do_op(16'd1234, 16'd0, kd, nb, gq, gr, gz);
    n_tests++;
    if (gq !== 16'hFFFF || gr !== 16'd1234 || gz !== 1'b1) begin
      n_fail++;
      $display("FAIL div_zero got q=%h r=%0d dz=%b exp q=ffff r=1234 dz=1", gq, gr, gz);
    end
    n_tests++;
    if (kd !== 0) begin
      n_fail++;
      $display("FAIL div_zero_latency got=%0d exp=1", kd + 1);
    end
    n_tests++;
    if (nb !== 0) begin
      n_fail++;
      $display("FAIL div_zero_busy got=%0d exp=0", nb);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, gq, gr, eq, er;
    logic gz, ez;
    int kd, nb;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'($urandom_range(1, 15));
        1: b = 16'($urandom_range(0, 255));
        default: b = 16'($urandom);
      endcase
      do_op(a, b, kd, nb, gq, gr, gz);
      ref_div(a, b, eq, er, ez);
      n_tests++;
      if (gq !== eq || gr !== er || gz !== ez) begin
        n_fail++;
        $display("FAIL random_%h/%h got q=%h r=%h dz=%b exp q=%h r=%h dz=%b",
                 a, b, gq, gr, gz, eq, er, ez);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int kd, nb;
    logic [15:0] gq, gr, eq, er;
    logic gz, ez;
    x = 16'd50000;
    y = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({busy, done, dz} !== 3'b000 || q !== 16'd0 || r !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_run got busy/done/dz=%b q=%h r=%h exp 000 0000 0000",
               {busy, done, dz}, q, r);
    end
    do_op(16'd40000, 16'd123, kd, nb, gq, gr, gz);
    ref_div(16'd40000, 16'd123, eq, er, ez);
    n_tests++;
    if (gq !== eq || gr !== er || gz !== ez || kd !== LAT - 1) begin
      n_fail++;
      $display("FAIL after_reset got q=%h r=%h dz=%b lat=%0d exp q=%h r=%h dz=%b lat=%0d",
               gq, gr, gz, kd + 1, eq, er, ez, LAT);
    end
  endtask

  task automatic test_back_to_back();
    int pulses[$];
    int p;
    logic [15:0] eq, er, lq, lr;
    logic ez;
    logic busy_gap, busy_restart;
    p = LAT + 1;
    busy_gap = 1'bx;
    busy_restart = 1'bx;
    lq = '0;
    lr = '0;
    x = 16'd60001;
    y = 16'd77;
    ref_div(x, y, eq, er, ez);
    start = 1'b1;
    tick();
    for (int k = 0; k < 2 * p + 2; k++) begin
      if (done) begin
        pulses.push_back(k);
        lq = q;
        lr = r;
      end
      if (k == LAT) busy_gap = busy;
      if (k == LAT + 1) busy_restart = busy;
      tick();
    end
    start = 1'b0;
    for (int k = 0; k < 60 && !done; k++) tick();
    tick();
    n_tests++;
    if (pulses.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_pulse_count got=%0d exp=2", pulses.size());
    end else begin
      n_tests++;
      if (pulses[0] != LAT - 1 || pulses[1] != LAT - 1 + p) begin
        n_fail++;
        $display("FAIL b2b_pulse_pos got=%0d,%0d exp=%0d,%0d",
                 pulses[0], pulses[1], LAT - 1, LAT - 1 + p);
      end
    end
    n_tests++;
    if (busy_gap !== 1'b0 || busy_restart !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_restart got gap/restart busy=%b%b exp=01", busy_gap, busy_restart);
    end
    n_tests++;
    if (lq !== eq || lr !== er) begin
      n_fail++;
      $display("FAIL b2b_result got q=%h r=%h exp q=%h r=%h", lq, lr, eq, er);
    end
  endtask

`ifdef DIV16_SIGNED_EN
  task automatic test_signed();
    int kd, nb;
    logic [15:0] gq, gr;
    logic gz;
    do_op(16'hFF9C, 16'd7, kd, nb, gq, gr, gz);
    n_tests++;
    if (gq !== 16'hFFF2 || gr !== 16'hFFFE || gz !== 1'b0 || kd !== 17) begin
      n_fail++;
      $display("FAIL signed_m100_7 got q=%h r=%h dz=%b lat=%0d exp q=fff2 r=fffe dz=0 lat=18",
               gq, gr, gz, kd + 1);
    end
    do_op(16'h8000, 16'hFFFF, kd, nb, gq, gr, gz);
    n_tests++;
    if (gq !== 16'h8000 || gr !== 16'h0000 || gz !== 1'b0) begin
      n_fail++;
      $display("FAIL signed_wrap got q=%h r=%h dz=%b exp q=8000 r=0000 dz=0", gq, gr, gz);
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail = 0;
    test_reset();
    test_directed();
    test_div_zero();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
`ifdef DIV16_SIGNED_EN
    test_signed();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
